// File: rtl/julia_pkg.sv
// Shared Julia/Mandelbrot frame constants and types.
// Solvers and the dispatcher agree on coordinate and index widths here.
package julia_pkg;

  localparam int FP_WIDTH      = 27;
  localparam int ROW_IDX_WIDTH = 9;
  localparam int COL_IDX_WIDTH = 10;
  localparam int NUM_ROWS      = 480;
  localparam int NUM_COLS      = 640;

  typedef logic [FP_WIDTH-1:0]      coord_t;
  typedef logic [ROW_IDX_WIDTH-1:0] row_idx_t;
  typedef logic [COL_IDX_WIDTH-1:0] col_idx_t;

  typedef enum logic {
    DISP_IDLE,
    DISP_RUN
  } disp_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request above ptr, wrapping.
// The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] k;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 1; i <= N; i++) begin
      k = PW'((int'(ptr) + i) % N);
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/row_dispatcher.sv
// Hands frame rows to a bank of row solvers, one grant per cycle,
// round-robin across solvers, stepping y by a fixed increment per row.
module row_dispatcher
  import julia_pkg::*;
#(
  parameter int NUM_SOLVERS = 4,
  parameter int NUM_ROWS    = julia_pkg::NUM_ROWS,
  parameter int FP_WIDTH    = julia_pkg::FP_WIDTH
) (
  input  logic                   solver_clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic [FP_WIDTH-1:0]    frame_x_reference,
  input  logic [FP_WIDTH-1:0]    frame_x_step,
  input  logic [FP_WIDTH-1:0]    frame_y_reference,
  input  logic [FP_WIDTH-1:0]    frame_y_step,
  input  logic [NUM_SOLVERS-1:0] start_request,
  output logic [NUM_SOLVERS-1:0] start_grant,
  output logic [FP_WIDTH-1:0]    row_x_reference,
  output logic [FP_WIDTH-1:0]    row_x_step,
  output logic [FP_WIDTH-1:0]    row_y,
  output logic [8:0]             row_y_idx,
  output logic                   frame_busy,
  output logic                   frame_dispatched
);

  localparam int PTR_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  localparam row_idx_t LAST_ROW = row_idx_t'(NUM_ROWS - 1);

  disp_state_t state, state_n;

  logic [PTR_W-1:0]       rr_ptr;
  row_idx_t               row_idx;
  logic [FP_WIDTH-1:0]    y_acc;
  logic [FP_WIDTH-1:0]    x_ref_q;
  logic [FP_WIDTH-1:0]    x_step_q;
  logic [FP_WIDTH-1:0]    y_step_q;

  logic [NUM_SOLVERS-1:0] eligible;
  logic [NUM_SOLVERS-1:0] pick;
  logic [PTR_W-1:0]       pick_idx;
  logic                   pick_any;

  logic                   latch;
  logic                   issue;
  logic                   last;

  // A solver drops its request only after sampling its grant,
  // so the solver granted last cycle is masked out.
  assign eligible = start_request & ~start_grant;

  rr_arbiter #(
    .N  (NUM_SOLVERS),
    .PW (PTR_W)
  ) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (pick),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_n = state;
    latch   = 1'b0;
    issue   = 1'b0;
    last    = 1'b0;
    unique case (state)
      DISP_IDLE: begin
        if (frame_start) begin
          latch   = 1'b1;
          state_n = DISP_RUN;
        end
      end
      DISP_RUN: begin
        if (pick_any) begin
          issue = 1'b1;
          if (row_idx == LAST_ROW) begin
            last    = 1'b1;
            state_n = DISP_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge solver_clk or posedge reset) begin
    if (reset) begin
      state            <= DISP_IDLE;
      rr_ptr           <= PTR_W'(NUM_SOLVERS - 1);
      row_idx          <= '0;
      y_acc            <= '0;
      x_ref_q          <= '0;
      x_step_q         <= '0;
      y_step_q         <= '0;
      start_grant      <= '0;
      row_x_reference  <= '0;
      row_x_step       <= '0;
      row_y            <= '0;
      row_y_idx        <= '0;
      frame_busy       <= 1'b0;
      frame_dispatched <= 1'b0;
    end else begin
      state            <= state_n;
      start_grant      <= issue ? pick : '0;
      frame_dispatched <= last;
      if (latch) begin
        x_ref_q    <= frame_x_reference;
        x_step_q   <= frame_x_step;
        y_step_q   <= frame_y_step;
        y_acc      <= frame_y_reference;
        row_idx    <= '0;
        frame_busy <= 1'b1;
      end
      if (issue) begin
        row_x_reference <= x_ref_q;
        row_x_step      <= x_step_q;
        row_y           <= y_acc;
        row_y_idx       <= row_idx;
        rr_ptr          <= pick_idx;
        row_idx         <= row_idx + 1'b1;
        y_acc           <= y_acc + y_step_q;
        if (last) frame_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_row_dispatcher.sv
// Bench for row_dispatcher: frame-level model plus directed scenarios.
// Solvers are emulated by a request process reacting to grants.
module tb_row_dispatcher;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic [26:0] xr_in, xs_in, yr_in, ys_in;
  logic [3:0]  req;
  logic [3:0]  start_grant;
  logic [26:0] row_x_reference, row_x_step, row_y;
  logic [8:0]  row_y_idx;
  logic        frame_busy, frame_dispatched;

  int checks = 0;
  int errors = 0;

  row_dispatcher #(
    .NUM_SOLVERS (4),
    .NUM_ROWS    (480),
    .FP_WIDTH    (27)
  ) dut (
    .solver_clk        (clk),
    .reset             (reset),
    .frame_start       (frame_start),
    .frame_x_reference (xr_in),
    .frame_x_step      (xs_in),
    .frame_y_reference (yr_in),
    .frame_y_step      (ys_in),
    .start_request     (req),
    .start_grant       (start_grant),
    .row_x_reference   (row_x_reference),
    .row_x_step        (row_x_step),
    .row_y             (row_y),
    .row_y_idx         (row_y_idx),
    .frame_busy        (frame_busy),
    .frame_dispatched  (frame_dispatched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, want);
    end
  endtask

  // Frame model: rows in order, y = y_ref + n*y_step, next solver is the
  // first requester after the last winner in circular order.
  logic [3:0]  exp_grant;
  logic [26:0] exp_xr, exp_xs, exp_y;
  logic [8:0]  exp_idx;
  logic        exp_busy, exp_disp;
  logic [26:0] p_xr, p_xs, p_ys, m_yacc;
  int          m_row, m_rr, m_pick;
  logic [3:0]  m_elig;
  logic [1:0]  m_k;

  always_comb begin
    m_elig = req & ~exp_grant;
    m_pick = -1;
    m_k    = '0;
    for (int j = 1; j <= 4; j++) begin
      m_k = 2'((m_rr + j) % 4);
      if (m_pick < 0 && m_elig[m_k]) m_pick = int'(m_k);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_grant <= '0; exp_xr <= '0; exp_xs <= '0; exp_y <= '0;
      exp_idx <= '0; exp_busy <= 1'b0; exp_disp <= 1'b0;
      p_xr <= '0; p_xs <= '0; p_ys <= '0; m_yacc <= '0;
      m_row <= 0; m_rr <= 3;
    end else begin
      exp_grant <= '0;
      exp_disp  <= 1'b0;
      if (!exp_busy) begin
        if (frame_start) begin
          p_xr <= xr_in; p_xs <= xs_in; p_ys <= ys_in;
          m_yacc <= yr_in; m_row <= 0; exp_busy <= 1'b1;
        end
      end else if (m_pick >= 0) begin
        exp_grant <= 4'b0001 << m_pick;
        exp_xr <= p_xr; exp_xs <= p_xs; exp_y <= m_yacc;
        exp_idx <= 9'(m_row);
        m_rr <= m_pick;
        m_row <= m_row + 1;
        m_yacc <= m_yacc + p_ys;
        if (m_row == 479) begin
          exp_disp <= 1'b1;
          exp_busy <= 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  logic [3:0] prev_g;
  initial begin
    prev_g = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("grant", 32'(start_grant), 32'(exp_grant));
        chk("busy", 32'(frame_busy), 32'(exp_busy));
        chk("dispatched", 32'(frame_dispatched), 32'(exp_disp));
        chk("row_x_ref", 32'(row_x_reference), 32'(exp_xr));
        chk("row_x_step", 32'(row_x_step), 32'(exp_xs));
        chk("row_y", 32'(row_y), 32'(exp_y));
        chk("row_y_idx", 32'(row_y_idx), 32'(exp_idx));
        chk("onehot0", 32'($onehot0(start_grant)), 32'd1);
        chk("no_repeat", 32'(start_grant & prev_g), 32'd0);
        prev_g = start_grant;
      end else begin
        prev_g = '0;
      end
    end
  end

  // Solver emulation: drop request on grant, re-raise after hold cycles.
  int         mode = 0;
  int         hold [4];
  logic [3:0] en;
  int         hold_len;
  initial begin
    req = '0;
    for (int i = 0; i < 4; i++) hold[i] = 0;
    forever begin
      @(negedge clk);
      en       = (mode == 1) ? 4'b0001 : (mode == 2) ? 4'b1111 : 4'b0000;
      hold_len = (mode == 1) ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
        if (!en[i]) begin
          req[i] = 1'b0;
        end else if (start_grant[i]) begin
          req[i]  = 1'b0;
          hold[i] = hold_len;
        end else if (!req[i]) begin
          if (hold[i] == 0) req[i] = 1'b1;
          else hold[i]--;
        end
      end
    end
  end

  task automatic wait_grant(output logic [3:0] g, output logic [26:0] y,
                            output logic [8:0] ix, output logic d);
    g = '0; y = '0; ix = '0; d = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (start_grant != 4'b0000) begin
        g = start_grant; y = row_y; ix = row_y_idx; d = frame_dispatched;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_grant: got no grant in 40 cycles, required a grant");
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  logic [3:0]  g;
  logic [26:0] y;
  logic [8:0]  ix;
  logic        d;
  int          guard;

  initial begin
    reset = 1'b1; frame_start = 1'b0;
    xr_in = 27'h1234567; xs_in = 27'h0000400;
    yr_in = 27'h0100000; ys_in = 27'h0000100;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_grant", 32'(start_grant), 32'h0);
    chk("rst_busy", 32'(frame_busy), 32'h0);
    chk("rst_row_y", 32'(row_y), 32'h0);

    // Single requester, slow re-request.
    mode = 1;
    @(negedge clk);
    frame_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_grant(g, y, ix, d);
      chk("single_grant", 32'(g), 32'h1);
      chk("single_y", 32'(y), 32'h0100000 + 32'(k) * 32'h100);
      chk("single_idx", 32'(ix), 32'(k));
      chk("single_xr", 32'(row_x_reference), 32'h1234567);
    end

    // All four requesting; run to the end of the frame.
    mode = 2;
    guard = 0;
    ix = '0;
    while (ix != 9'd479 && guard < 600) begin
      wait_grant(g, y, ix, d);
      guard++;
    end
    chk("last_idx", 32'(ix), 32'd479);
    chk("last_disp", 32'(d), 32'd1);
    @(negedge clk);
    chk("end_busy", 32'(frame_busy), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("end_no_grant", 32'(start_grant), 32'd0);
    end

    // Fresh frame after reset: round-robin order and restart ignore.
    pulse_reset();
    xr_in = 27'h2AAAAAA; xs_in = 27'h7FFFC00;
    yr_in = 27'h0100000; ys_in = 27'h0000100;
    @(negedge clk);
    frame_start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_grant(g, y, ix, d);
      chk("rr_order", 32'(g), 32'(4'b0001 << (k % 4)));
      chk("rr_idx", 32'(ix), 32'(k));
      chk("rr_xr", 32'(row_x_reference), 32'h2AAAAAA);
      chk("rr_xs", 32'(row_x_step), 32'h7FFFC00);
    end
    guard = 0;
    while (ix != 9'd50 && guard < 100) begin
      wait_grant(g, y, ix, d);
      guard++;
    end
    yr_in = 27'h0500000;
    frame_start = 1'b1;
    wait_grant(g, y, ix, d);
    chk("restart_idx", 32'(ix), 32'd51);
    chk("restart_y", 32'(y), 32'h0103300);
    guard = 0;
    while (ix != 9'd100 && guard < 100) begin
      wait_grant(g, y, ix, d);
      guard++;
    end

    // Asynchronous reset in the middle of a cycle.
    #2 reset = 1'b1;
    #1;
    chk("async_grant", 32'(start_grant), 32'h0);
    chk("async_busy", 32'(frame_busy), 32'h0);
    chk("async_y", 32'(row_y), 32'h0);
    chk("async_xr", 32'(row_x_reference), 32'h0);
    chk("async_idx", 32'(row_y_idx), 32'h0);
    #1 reset = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    wait_grant(g, y, ix, d);
    chk("post_rst_grant", 32'(g), 32'h1);
    chk("post_rst_idx", 32'(ix), 32'h0);
    chk("post_rst_y", 32'(y), 32'h0500000);

    // Silent wrap of the y accumulator.
    pulse_reset();
    yr_in = 27'h7FFFF00; ys_in = 27'h0000200;
    @(negedge clk);
    frame_start = 1'b1;
    wait_grant(g, y, ix, d);
    chk("wrap_y0", 32'(y), 32'h7FFFF00);
    wait_grant(g, y, ix, d);
    chk("wrap_y1", 32'(y), 32'h0000100);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/row_dispatcher.md
# row_dispatcher

Issues rows of a Julia/Mandelbrot frame to a bank of row solvers. It answers each solver's `start_request` with a one-hot `start_grant`, presented together with that row's coordinates on a shared row bus. It walks rows 0..NUM_ROWS-1 once per frame and steps the imaginary coordinate by a fixed increment per row. It sits between the frame-setup logic (HPS/PIO parameters) and the `start_request`/`start_grant` ports of every solver instance.

## Interface
- `NUM_SOLVERS`, default 4: number of attached solvers, range 1..16.
- `NUM_ROWS`, default 480: rows per frame, at most 512.
- `FP_WIDTH`, default 27: fixed-point coordinate width.

Ports:
- `solver_clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high.
- `frame_start`  in  1  one-cycle pulse; latches frame parameters and starts dispatch.
- `frame_x_reference`  in  FP_WIDTH  real coordinate of column 0; the same value is used for every row.
- `frame_x_step`  in  FP_WIDTH  real increment per column.
- `frame_y_reference`  in  FP_WIDTH  imaginary coordinate of row 0.
- `frame_y_step`  in  FP_WIDTH  imaginary increment per row, two's complement.
- `start_request`  in  NUM_SOLVERS  bit i high while solver i is idle and wants a row.
- `start_grant`  out  NUM_SOLVERS  registered, one-hot or zero.
- `row_x_reference`, `row_x_step`, `row_y`  out  FP_WIDTH each  row bus; valid while any grant bit is high.
- `row_y_idx`  out  9  row index on the row bus.
- `frame_busy`  out  1  high from frame latch until the last row is granted.
- `frame_dispatched`  out  1  one-cycle pulse, coincident with the grant of row NUM_ROWS-1.

## Operation
- States:
  - IDLE: the reset state.
  - DISPATCH.
- IDLE behaviour:
  - `frame_start` high latches all four frame inputs.
  - Sets `row_idx`=0 and `y_acc`=`frame_y_reference`.
  - Transitions to DISPATCH and sets `frame_busy`=1.
- DISPATCH, each cycle:
  - Eligible set: `start_request & ~start_grant`. A solver drops its request only on the edge at which it samples its grant, so this mask prevents a double grant.
  - If the eligible set is non-zero, select the first eligible solver searching from `rr_ptr+1` upward, wrapping at NUM_SOLVERS.
  - Register the one-hot `start_grant` for the selected solver.
  - Drive the row bus with `frame_x_reference`, `frame_x_step`, `y_acc`, `row_idx`.
  - Set `rr_ptr` to the selected index, increment `row_idx`, and set `y_acc` to `y_acc + frame_y_step` (modulo 2^FP_WIDTH; wrap is silent).
  - If the eligible set is zero, `start_grant`=0 and the row bus holds its last value.
- Last row: when the granted row is NUM_ROWS-1:
  - `frame_dispatched` pulses in the same cycle as that grant.
  - `frame_busy` falls on the same edge.
  - State returns to IDLE.
- `frame_start` during DISPATCH is ignored; the frame in progress is unchanged.
- Requests arriving in IDLE are never granted.
- Reset, at any time including mid-frame:
  - `start_grant`=0, row bus=0, `row_y_idx`=0, `frame_busy`=0, `frame_dispatched`=0.
  - State=IDLE, `rr_ptr`=NUM_SOLVERS-1, so solver 0 has first priority.
  - Rows already granted are not tracked or re-issued.

## Timing
- All outputs are registered.
- `frame_start` sampled at edge E0: `frame_busy` is high after E0. The earliest grant is visible after E1.
- Grant and row bus are valid for exactly one cycle per grant. The solver samples both on the edge ending that cycle.
- Back-to-back grants to different solvers in consecutive cycles are allowed.
- The same solver is never granted in two consecutive cycles.
- Throughput: at most 1 row per cycle. The minimum frame dispatch time is NUM_ROWS cycles.
- A request that is continuously asserted is granted within NUM_SOLVERS cycles (round-robin fairness).

## Structure
- Shared package `julia_pkg` holds:
  - FP_WIDTH=27, ROW_IDX_WIDTH=9, COL_IDX_WIDTH=10.
  - NUM_ROWS=480, NUM_COLS=640.
  - The coordinate typedef, so solver and dispatcher agree on widths.
- One sub-module: `rr_arbiter`.
  - Parameterised by N.
  - Combinational one-hot pick from a request vector and a pointer; the pointer register lives in the dispatcher.
- Everything else is a two-state FSM plus row counter and accumulator in `row_dispatcher`.

## Test plan
- Single requester: NUM_SOLVERS=4, y_ref=0x0100000, y_step=0x0000100, only solver 0 requests, and the bench model re-requests 2 cycles after each grant. Required: grants only on bit 0; `row_y` sequence 0x0100000, 0x0100100, 0x0100200; `row_y_idx` 0,1,2.
- All four solvers requesting continuously (model drops the request on grant and re-raises it the next cycle). Required: grant order 0,1,2,3,0,…; no bit high in two consecutive cycles; `row_x_*` equal the frame inputs on every grant.
- Frame end with NUM_ROWS=480. Required: the 480th grant carries `row_y_idx`=479 with `frame_dispatched`=1; `frame_busy`=0 afterwards; later requests get no grant.
- `frame_start` pulsed again at row 50 with a different y_ref. Required: rows 51.. continue from the original y_ref progression.
- Asynchronous reset asserted mid-cycle at row 100. Required: all outputs 0 immediately. A following `frame_start` restarts at `row_y_idx`=0 with solver 0 granted first.
- Wrap: y_ref=0x7FFFF00, y_step=0x0000200. Required: row 1 `row_y`=0x0000100.
